// File: rtl/paged_stub_memory.sv
// BX-paged stub-pair memory: one producer writes the current BX page while
// consumers read any page together with its committed count and overflow flag.
module paged_stub_memory #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned PAGE_BITS  = 1,
  parameter int unsigned TMUX       = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en_proc,
  input  logic [1:0]                     start,
  output logic [1:0]                     done,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           enable,
  input  logic [PAGE_BITS+ADDR_BITS-1:0] read_add,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [ADDR_BITS:0]             number_out,
  output logic                           overflow_out
);

  localparam int unsigned NPAGES = 2 ** PAGE_BITS;
  localparam int unsigned DEPTH  = 2 ** ADDR_BITS;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                     state;
  logic [PAGE_BITS-1:0]           wp;
  logic [PAGE_BITS-1:0]           wp_next;
  logic [ADDR_BITS:0]             wcnt;
  logic [ADDR_BITS:0]             wcnt_next;
  logic [ADDR_BITS:0]             cnt [NPAGES];
  logic [NPAGES-1:0]              ovf;
  logic                           accept;
  logic                           do_write;
  logic                           page_full;
  logic [PAGE_BITS+ADDR_BITS-1:0] waddr;

  logic                           wr_en_q;
  logic [PAGE_BITS+ADDR_BITS-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]          wr_data_q;

  logic [DATA_WIDTH-1:0]          mem [NPAGES*DEPTH];
  logic [DATA_WIDTH-1:0]          ram_q;
  logic [PAGE_BITS-1:0]           rpage;
  logic [1:0]                     dly [TMUX];

  // wcnt only ever reaches DEPTH, so its top bit alone marks a full page
  assign page_full = wcnt[ADDR_BITS];
  assign rpage     = read_add[PAGE_BITS+ADDR_BITS-1 -: PAGE_BITS];

  always_comb begin
    accept    = enable && en_proc && (state == RUN) && !start[1];
    wp_next   = wp;
    wcnt_next = wcnt;
    do_write  = 1'b0;
    waddr     = {wp, wcnt[ADDR_BITS-1:0]};
    if (start[0]) begin
      // an entry arriving with the strobe becomes entry 0 of the new page
      wp_next   = wp + 1'b1;
      wcnt_next = accept ? {{ADDR_BITS{1'b0}}, 1'b1} : '0;
      do_write  = accept;
      waddr     = {wp_next, {ADDR_BITS{1'b0}}};
    end else if (accept && !page_full) begin
      wcnt_next = wcnt + 1'b1;
      do_write  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wp        <= '1;
      wcnt      <= '0;
      ovf       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int unsigned i = 0; i < NPAGES; i++) cnt[i] <= '0;
    end else if (start[1]) begin
      state     <= IDLE;
      wp        <= '1;
      wcnt      <= '0;
      ovf       <= '0;
      wr_en_q   <= 1'b0;
      for (int unsigned i = 0; i < NPAGES; i++) cnt[i] <= '0;
    end else begin
      if (start[0]) state <= RUN;
      wp        <= wp_next;
      wcnt      <= wcnt_next;
      cnt[wp_next] <= wcnt_next;
      if (start[0]) ovf[wp_next] <= 1'b0;
      else if (accept && page_full) ovf[wp] <= 1'b1;
      wr_en_q   <= do_write;
      wr_addr_q <= waddr;
      wr_data_q <= data_in;
    end
  end

  // storage array carries no reset: validity is defined solely by the counts
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q        <= '0;
      data_out     <= '0;
      number_out   <= '0;
      overflow_out <= 1'b0;
    end else begin
      ram_q        <= mem[read_add];
      data_out     <= ram_q;
      number_out   <= cnt[rpage];
      overflow_out <= ovf[rpage];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < TMUX; i++) dly[i] <= '0;
    end else begin
      dly[0] <= start;
      for (int unsigned i = 1; i < TMUX; i++) dly[i] <= dly[i-1];
    end
  end

  assign done = dly[TMUX-1];

endmodule

// File: tb/tb_paged_stub_memory.sv
// Scoreboard bench for paged_stub_memory: reads and strobes push expected
// outputs with a due cycle; a negedge checker pops and compares them.
module tb_paged_stub_memory;

  localparam int unsigned DW = 12;
  localparam int unsigned AB = 6;
  localparam int unsigned PB = 2;
  localparam int unsigned TM = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en_proc = 1'b1;
  logic [1:0]    start = '0;
  logic [1:0]    done;
  logic [DW-1:0] data_in = '0;
  logic          enable = 1'b0;
  logic [PB+AB-1:0] read_add = '0;
  logic [DW-1:0] data_out;
  logic [AB:0]   number_out;
  logic          overflow_out;

  paged_stub_memory #(
    .DATA_WIDTH(DW),
    .ADDR_BITS (AB),
    .PAGE_BITS (PB),
    .TMUX      (TM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en_proc     (en_proc),
    .start       (start),
    .done        (done),
    .data_in     (data_in),
    .enable      (enable),
    .read_add    (read_add),
    .data_out    (data_out),
    .number_out  (number_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          due;
    int          kind;   // 0 data_out, 1 number_out, 2 overflow_out, 3 done
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        logic [31:0] act;
        case (q[i].kind)
          0:       act = 32'(data_out);
          1:       act = 32'(number_out);
          2:       act = 32'(overflow_out);
          default: act = 32'(done);
        endcase
        if (q[i].due < cyc) check({q[i].tag, "_late"}, 32'hdead, q[i].exp);
        else                check(q[i].tag, act, q[i].exp);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input string tag, input int due, input int kind, input logic [31:0] exp);
    item_t it;
    it.tag = tag; it.due = due; it.kind = kind; it.exp = exp;
    q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] s);
    start = s;
    tick();
    start = '0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    enable = 1'b1;
    data_in = d;
    tick();
    enable = 1'b0;
  endtask

  // chk_data=0 skips data_out (entry contents undefined)
  task automatic rd(input string tag, input int page, input int entry, input bit chk_data,
                    input logic [31:0] exp_d, input logic [31:0] exp_n, input logic [31:0] exp_o);
    read_add = {2'(page), 6'(entry)};
    push({tag, "_num"}, cyc + 1, 1, exp_n);
    push({tag, "_ovf"}, cyc + 1, 2, exp_o);
    if (chk_data) push({tag, "_data"}, cyc + 2, 0, exp_d);
    tick();
  endtask

  initial begin
    int sc;
    #1 reset = 1'b1;
    #2;
    check("rst_data", 32'(data_out), 0);
    check("rst_num", 32'(number_out), 0);
    check("rst_ovf", 32'(overflow_out), 0);
    check("rst_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    tick();

    // first BX: five writes into page 0, done latency on the strobe
    push("done_early", cyc + TM - 1, 3, 0);
    push("done_01", cyc + TM, 3, 1);
    strobe(2'b01);
    for (int i = 1; i <= 5; i++) wr(DW'(12'h100 + i));
    tick(); tick();
    for (int i = 0; i < 5; i++) rd("p0", 0, i, 1, 32'h101 + i, 5, 0);
    tick(); tick();

    // overflow: 67 writes into page 1
    strobe(2'b01);
    for (int i = 0; i < 67; i++) wr(DW'(12'h200 + i));
    tick(); tick();
    rd("ovf_e63", 1, 63, 1, 32'h200 + 63, 64, 1);
    rd("ovf_e0", 1, 0, 1, 32'h200, 64, 1);
    strobe(2'b01);
    rd("newpg", 2, 0, 0, 0, 0, 0);
    rd("oldpg", 1, 5, 1, 32'h205, 64, 1);
    tick(); tick();

    // pipelined reset clears every page, then four pages plus a wrap
    strobe(2'b10);
    rd("clr", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      strobe(2'b01);
      for (int j = 0; j <= k; j++) wr(DW'(12'h300 + k));
    end
    tick(); tick();
    for (int k = 0; k < 4; k++) rd("pg", k, k, 1, 32'h300 + k, k + 1, 0);
    tick(); tick();
    strobe(2'b01);
    rd("wrap_clr", 0, 0, 1, 32'h300, 0, 0);
    for (int j = 0; j < 5; j++) wr(12'h304);
    tick(); tick();
    rd("wrap_e4", 0, 4, 1, 32'h304, 5, 0);
    rd("wrap_p1", 1, 1, 1, 32'h301, 2, 0);
    tick(); tick();

    // strobe with data, then start[1] beating start[0] and enable
    start = 2'b01; enable = 1'b1; data_in = 12'hABC;
    tick();
    start = '0; enable = 1'b0;
    tick(); tick();
    rd("same_cyc", 1, 0, 1, 32'hABC, 1, 0);
    start = 2'b11; enable = 1'b1; data_in = 12'hDEF;
    tick();
    start = '0;
    data_in = 12'h555;
    tick(); tick(); tick();
    enable = 1'b0;
    tick(); tick();
    rd("idle_p3", 3, 0, 1, 32'h303, 0, 0);
    rd("idle_p1", 1, 0, 1, 32'hABC, 0, 0);
    strobe(2'b01);
    wr(12'h777);
    tick(); tick();
    rd("wp_ones", 0, 0, 1, 32'h777, 1, 0);
    rd("wp_old", 0, 1, 1, 32'h304, 1, 0);
    tick(); tick();

    // en_proc low suppresses writes
    strobe(2'b01);
    en_proc = 1'b0;
    enable = 1'b1; data_in = 12'hBAD;
    for (int i = 0; i < 10; i++) tick();
    enable = 1'b0; en_proc = 1'b1;
    tick(); tick();
    rd("noproc", 1, 0, 1, 32'hABC, 0, 0);
    tick(); tick();

    // async reset mid-page
    strobe(2'b01);
    wr(12'h901); wr(12'h902); wr(12'h903);
    tick();
    rd("pre_rst", 2, 0, 1, 32'h901, 3, 0);
    tick();
    sc = cyc;
    push("done_rst", sc + TM, 3, 0);
    strobe(2'b01);
    #2 reset = 1'b1;
    #1;
    check("arst_data", 32'(data_out), 0);
    check("arst_num", 32'(number_out), 0);
    check("arst_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    rd("post_rst", 2, 0, 1, 32'h901, 0, 0);

    for (int i = 0; i < 10; i++) tick();
    while (q.size() > 0) begin
      check({q[0].tag, "_timeout"}, 32'hdead, q[0].exp);
      void'(q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paged_stub_memory.md
# paged_stub_memory

Parametrised, BX-paged stub-pair memory for the tracklet processing chain. Entries from one upstream producer are written into the page selected by a rotating BX page counter, while downstream consumers read any page by address together with its committed entry count and overflow flag. It generalises the fixed 12-bit, 2-page stub-pair memory to configurable data width, depth and page count. It adds saturating overflow protection and per-page counts for every page, not only the most recent one.

## Interface
- DATA_WIDTH, 12, stored word width
- ADDR_BITS, 6, log2 entries per page (DEPTH = 2**ADDR_BITS)
- PAGE_BITS, 1, log2 number of BX pages (NPAGES = 2**PAGE_BITS, PAGE_BITS >= 1)
- TMUX, 6, delay in cycles from start to done
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- en_proc  in  1  processing enable; when low, writes are suppressed and the page counter still advances on start
- start  in  2  bit0 = new-BX strobe, bit1 = pipelined reset
- done  out  2  start delayed by exactly TMUX cycles
- data_in  in  DATA_WIDTH  entry to store
- enable  in  1  data_in valid this cycle
- read_add  in  PAGE_BITS+ADDR_BITS  {page, entry} read address
- data_out  out  DATA_WIDTH  registered read data
- number_out  out  ADDR_BITS+1  committed entry count of page read_add[top PAGE_BITS]
- overflow_out  out  1  sticky overflow flag of that same page

## Operation
- Write page pointer wp (PAGE_BITS wide) rotates modulo NPAGES.
- Write counter wcnt (ADDR_BITS+1 wide) counts entries in the current page.
- Per-page registers: cnt[p] (ADDR_BITS+1 wide) and ovf[p].
- State: IDLE (after reset or start[1]) and RUN (after the first start[0]). Writes are accepted only in RUN.
- start[1]: wp <= all ones, wcnt <= 0, all cnt and ovf cleared, state <= IDLE. start[1] has priority over start[0] and enable in the same cycle.
- start[0] (without start[1]):
  - wp <= wp+1, wrapping from NPAGES-1 to 0.
  - wcnt <= 0, or 1 if enable is accepted in the same cycle.
  - cnt[new wp] and ovf[new wp] cleared.
  - state <= RUN.
- An entry is accepted when enable && en_proc && state==RUN && !start[1].
  - Accepted with wcnt < DEPTH: data_in is written to {wp, wcnt[ADDR_BITS-1:0]} and wcnt increments.
  - With start[0] in the same cycle, the entry is the first entry (address 0) of the new page.
  - Accepted with wcnt == DEPTH: no write, wcnt holds at DEPTH, ovf[wp] <= 1.
- cnt[wp] tracks wcnt live: a write in cycle t is visible in cnt from cycle t+1.
- Memory contents are never cleared. Only the counts define validity.
- Reads are unrestricted, including reads of the page currently being written.

## Timing
- Write path: data_in/enable are registered once, and the RAM write occurs one cycle after acceptance.
- Same-page read-after-write is valid for reads issued 2 or more cycles after acceptance.
- data_out: 2-cycle latency from read_add (RAM output register plus output register).
- number_out and overflow_out: 1-cycle latency from read_add.
- done: start registered through TMUX stages; done == start from TMUX cycles earlier, both bits independent.
- Reset values:
  - done = 0, data_out = 0, number_out = 0, overflow_out = 0.
  - wp = all ones, wcnt = 0, all cnt and ovf = 0, state = IDLE.
- Reset asserted mid-page: all registers clear immediately (asynchronously). An in-flight write is dropped.
- Continuous start[0] every cycle is legal: each page holds at most 1 entry.
- Wrap behaviour:
  - After NPAGES start[0] strobes, wp returns to its starting page. That page's count and flag are cleared on entry.
  - Its old data remain until overwritten.

## Test plan
- Reset, then start[0], then 5 accepted writes 0x101..0x105. Read page 0, entries 0-4 → data_out = 0x101..0x105 two cycles after each address; number_out = 5, overflow_out = 0.
- DEPTH+3 = 67 accepted writes in one page → number_out = 64, overflow_out = 1, entry 63 = 64th word. The next start[0] gives the new page count 0 and flag 0.
- PAGE_BITS=2: 5 start[0] strobes, each page written with its index as data, k+1 entries → pages 0-3 counts visible; page 0 is re-entered on the 5th strobe and cleared to its new count.
- start[0] and enable in the same cycle with data 0xABC → stored at the new page entry 0, count 1. start[1] together with start[0] → wp = all ones, state IDLE, and a following enable is ignored.
- en_proc = 0 with enable high for 10 cycles → count stays 0. Async reset pulsed mid-page → all outputs 0 within the same cycle and done cleared. Start pattern 2'b01 → done = 2'b01 exactly TMUX = 6 cycles later.
